// File: rtl/fetch_ctl.sv
// Fetch sequencing controller: PC/IF-ID enables, flushes and imem request.
// Optional redirect performance counter enabled by FETCH_PERF_CNT_EN.
module fetch_ctl #(
  parameter logic [4:0] HALT_OP      = 5'b00000,
  parameter logic [7:0] IMEM_TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] if_inst,
  input  logic        br_ctl,
  input  logic        jump,
  input  logic        hazard_stall,
  input  logic        dmem_stall,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        halt,
  output logic        imem_err,
  output logic [15:0] redirect_cnt
);

  typedef enum logic [2:0] {IDLE, RUN, IMEM_WAIT, DISCARD, HALT} state_t;

  state_t     state, state_nxt;
  logic [7:0] tmo_cnt, tmo_nxt;
  logic       halt_q, halt_nxt;
  logic       err_q, err_nxt;

  logic redirect, op_halt;
  logic run_pc, run_en, run_iff, run_idf, run_halt;
  logic unused_inst_bits;

  assign redirect         = br_ctl | jump;
  assign op_halt          = (if_inst[15:11] == HALT_OP);
  assign unused_inst_bits = ^if_inst[10:0];

  // Shared RUN priority chain without the imem_stall rule; reused by IMEM_WAIT on done.
  always_comb begin
    run_pc   = 1'b0;
    run_en   = 1'b0;
    run_iff  = 1'b0;
    run_idf  = 1'b0;
    run_halt = 1'b0;
    if (dmem_stall) begin
      run_pc = 1'b0;
    end else if (redirect) begin
      run_pc  = 1'b1;
      run_en  = 1'b1;
      run_iff = 1'b1;
    end else if (hazard_stall) begin
      run_idf = 1'b1;
    end else if (op_halt) begin
      run_en   = 1'b1;
      run_halt = 1'b1;
    end else begin
      run_pc = 1'b1;
      run_en = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    tmo_nxt     = tmo_cnt;
    halt_nxt    = halt_q;
    err_nxt     = err_q;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        imem_req = 1'b1;
        if (imem_stall && !dmem_stall && !redirect) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          state_nxt   = IMEM_WAIT;
          tmo_nxt     = 8'd1;
          if (tmo_nxt == IMEM_TIMEOUT) err_nxt = 1'b1;
        end else begin
          pc_en       = run_pc;
          if_id_en    = run_en;
          if_id_flush = run_iff;
          id_ex_flush = run_idf;
          // A redirect racing an outstanding fetch must drop the wrong-path data.
          if (!dmem_stall && redirect && imem_stall) begin
            state_nxt = DISCARD;
          end else if (run_halt) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end
        end
      end
      IMEM_WAIT: begin
        imem_req = 1'b1;
        if (imem_done) begin
          pc_en       = run_pc;
          if_id_en    = run_en;
          if_id_flush = run_iff;
          id_ex_flush = run_idf;
          tmo_nxt     = '0;
          if (run_halt) begin
            state_nxt = HALT;
            halt_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end else if (imem_stall) begin
          if_id_en    = 1'b1;
          if_id_flush = 1'b1;
          tmo_nxt     = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
          if (tmo_nxt == IMEM_TIMEOUT) err_nxt = 1'b1;
        end
      end
      DISCARD: begin
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        if (imem_done) state_nxt = RUN;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      halt_q  <= halt_nxt;
      err_q   <= err_nxt;
    end
  end

  assign halt     = halt_q;
  assign imem_err = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic        redir_take;
  logic [15:0] rc_q;

  assign redir_take = redirect && !dmem_stall &&
                      ((state == RUN) || ((state == IMEM_WAIT) && imem_done));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rc_q <= '0;
    else if (redir_take) rc_q <= rc_q + 16'd1;
  end

  assign redirect_cnt = rc_q;
`else
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctl.sv
// Directed scoreboard bench for fetch_ctl (IMEM_TIMEOUT overridden to 4).
module tb_fetch_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req, imem_stall, imem_done;
  logic [15:0] if_inst;
  logic        br_ctl, jump, hazard_stall, dmem_stall;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halt, imem_err;
  logic [15:0] redirect_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] rc = '0;

  localparam logic [15:0] NOP = 16'hC001;
  localparam logic [15:0] HLT = 16'h07FF;

  typedef struct {
    string       tag;
    logic [6:0]  v;
    logic [15:0] c;
  } exp_t;
  exp_t sb[$];

  fetch_ctl #(.HALT_OP(5'b00000), .IMEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_stall(imem_stall),
    .imem_done(imem_done), .if_inst(if_inst), .br_ctl(br_ctl), .jump(jump),
    .hazard_stall(hazard_stall), .dmem_stall(dmem_stall), .pc_en(pc_en),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halt(halt), .imem_err(imem_err), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Expected vector order: {imem_req, pc_en, if_id_en, if_id_flush, id_ex_flush, halt, imem_err}
  task automatic step(input string tag, input logic b, input logic j, input logic h,
                      input logic d, input logic is, input logic id,
                      input logic [15:0] inst, input logic [6:0] ev, input logic bump);
    exp_t e;
    logic [6:0] obs;
    br_ctl = b; jump = j; hazard_stall = h; dmem_stall = d;
    imem_stall = is; imem_done = id; if_inst = inst;
    sb.push_back('{tag, ev, rc});
    @(negedge clk);
    obs = {imem_req, pc_en, if_id_en, if_id_flush, id_ex_flush, halt, imem_err};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty, actual=none required=entry", tag);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_bad++;
        $error("FAIL %s outs: actual=%b required=%b", e.tag, obs, e.v);
      end
      n_cmp++;
      assert (redirect_cnt === e.c) else begin
        n_bad++;
        $error("FAIL %s redirect_cnt: actual=%0d required=%0d", e.tag, redirect_cnt, e.c);
      end
    end
    if (bump) begin
`ifdef FETCH_PERF_CNT_EN
      rc = rc + 16'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    br_ctl = 0; jump = 0; hazard_stall = 0; dmem_stall = 0;
    imem_stall = 0; imem_done = 0; if_inst = NOP;
    step("reset",      0,0,0,0,0,0, NOP, 7'b0000000, 0);
    rst = 1'b1;
    step("idle",       0,0,0,0,0,0, NOP, 7'b0000000, 0);
    step("run0",       0,0,0,0,0,0, NOP, 7'b1110000, 0);
    step("run1",       0,0,0,0,0,0, NOP, 7'b1110000, 0);
    step("branch",     1,0,0,0,0,0, NOP, 7'b1111000, 1);
    step("after_br",   0,0,0,0,0,0, NOP, 7'b1110000, 0);
    step("istall1",    0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("istall2",    0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("istall3",    0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("idone",      0,0,0,0,0,1, NOP, 7'b1110000, 0);
    step("run2",       0,0,0,0,0,0, NOP, 7'b1110000, 0);
    step("jump_stall", 0,1,0,0,1,0, NOP, 7'b1111000, 1);
    step("discard",    0,0,0,0,1,0, NOP, 7'b0011000, 0);
    step("disc_done",  0,0,0,1,0,1, NOP, 7'b0011000, 0);
    step("refetch",    0,0,0,0,0,0, NOP, 7'b1110000, 0);
    step("hazard",     0,0,1,0,0,0, NOP, 7'b1000100, 0);
    step("dmem_br",    1,0,0,1,0,0, NOP, 7'b1000000, 0);
    step("br_release", 1,0,0,0,0,0, NOP, 7'b1111000, 1);
    step("tmo1",       0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("tmo2",       0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("tmo3",       0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("tmo4",       0,0,0,0,1,0, NOP, 7'b1011000, 0);
    step("tmo5",       0,0,0,0,1,0, NOP, 7'b1011001, 0);
    step("tmo6",       0,0,0,0,1,0, NOP, 7'b1011001, 0);
    step("tmo_done",   0,0,0,0,0,1, NOP, 7'b1110001, 0);
    step("err_sticky", 0,0,0,0,0,0, NOP, 7'b1110001, 0);
    step("br_haltop",  1,0,0,0,0,0, HLT, 7'b1111001, 1);
    step("haltop",     0,0,0,0,0,0, HLT, 7'b1010001, 0);
    step("halted1",    1,0,0,0,0,0, NOP, 7'b0000011, 0);
    step("halted2",    0,0,0,0,0,0, NOP, 7'b0000011, 0);
    rst = 1'b0;
    rc  = '0;
    step("reset2",     0,0,0,0,0,0, NOP, 7'b0000000, 0);
    rst = 1'b1;
    step("idle2",      0,0,0,0,0,0, NOP, 7'b0000000, 0);
    step("run_clean",  0,0,0,0,0,0, NOP, 7'b1110000, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctl.md
Name: fetch_ctl

Overview:
Sequencing controller for the 16-bit program counter and IF/ID/ID-EX pipeline registers. Generates the PC write enable, pipeline enables and flushes, and the instruction-memory fetch request. Arbitrates between branch/jump redirects, instruction-memory stalls, data-memory stalls, load-use hazards and HALT. Sits beside the PC register; its pc_en drives the PC register's write enable.

Parameters:
HALT_OP, 5'b00000, opcode in if_inst[15:11] that stops fetch
IMEM_TIMEOUT, 15, max consecutive imem stall cycles before imem_err; width 8 bits, legal range 1..255

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
imem_req  out  1  fetch request for the current PC
imem_stall  in  1  instruction memory not ready this cycle
imem_done  in  1  instruction data valid (stall ended)
if_inst  in  16  instruction returned by instruction memory
br_ctl  in  1  branch taken, resolved from ID instruction
jump  in  1  jump decoded in ID
hazard_stall  in  1  load-use hazard detected in ID
dmem_stall  in  1  data memory stall, freezes the whole pipe
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID register write enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_flush  out  1  load NOP into ID/EX
halt  out  1  sticky halt indication
imem_err  out  1  sticky imem timeout flag
redirect_cnt  out  16  redirects taken (see Optional Feature)

Behaviour:
- States: IDLE, RUN, IMEM_WAIT, DISCARD, HALT. Registered state; outputs combinational from state and inputs.
- Reset (rst=0, async): state=IDLE, halt=0, imem_err=0, timeout counter=0, redirect_cnt=0. In IDLE all outputs 0.
- IDLE: next cycle -> RUN unconditionally.
- RUN, imem_req=1. Priority, highest first:
  1. dmem_stall=1: pc_en=0, if_id_en=0, no flushes. Stay in RUN.
  2. redirect (br_ctl|jump):
     - pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=0.
     - If imem_stall=1: go to DISCARD, because the in-flight fetch is wrong-path.
     - Else stay in RUN.
     - redirect_cnt+1.
  3. imem_stall=1: pc_en=0, if_id_en=1, if_id_flush=1 (bubble into ID, ID drains). Go to IMEM_WAIT; timeout counter=1.
  4. hazard_stall=1: pc_en=0, if_id_en=0, id_ex_flush=1.
  5. if_inst[15:11]==HALT_OP: pc_en=0, if_id_en=1. Go to HALT; halt=1.
  6. Otherwise: pc_en=1, if_id_en=1.
- IMEM_WAIT, imem_req=1, pc_en=0, if_id_flush=1 each cycle while imem_stall=1.
  - Timeout counter increments, saturating at 255. On reaching IMEM_TIMEOUT, imem_err=1 (sticky until reset); state is unaffected.
  - imem_done=1: treated exactly as RUN in the same cycle, rules 1, 2, 4, 5, 6 with imem_stall ignored. Then -> RUN or HALT; counter cleared.
  - A redirect while waiting is held by the datapath and not applied until imem_done.
- DISCARD, imem_req=0, pc_en=0, if_id_flush=1.
  - On imem_done: data dropped, -> RUN; new fetch request next cycle.
  - dmem_stall does not delay the discard.
- HALT: all enables 0, imem_req=0, halt=1. Left only by reset.
- Redirect and HALT_OP in the same cycle: the redirect wins; the halt is wrong-path and ignored.
- dmem_stall together with a redirect: the freeze wins; the redirect is applied on the first cycle dmem_stall=0. The datapath holds br_ctl/jump while frozen.
- Never assert pc_en and if_id_flush=0 while imem_stall=1 in RUN.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: redirect_cnt is a 16-bit counter, incremented once per applied redirect, wrapping from 16'hFFFF to 0, cleared by reset.
- Undefined: redirect_cnt tied to 16'h0000 and no counter flops are synthesized.

Test Plan:
- Reset release, no stalls, if_inst=16'hC001 -> IDLE for 1 cycle, then pc_en=1 and if_id_en=1 every cycle; halt=0.
- br_ctl=1 for 1 cycle in RUN, imem_stall=0 -> that cycle pc_en=1, if_id_flush=1; redirect_cnt 0->1 with macro, stays 0 without.
- imem_stall=1 for 3 cycles, then imem_done=1 -> pc_en=0 and if_id_flush=1 for 3 cycles, pc_en=1 on the done cycle; imem_err stays 0.
- jump=1 with imem_stall=1 -> pc_en=1 that cycle, then DISCARD with imem_req=0; on imem_done, if_id_flush=1; next cycle imem_req=1.
- IMEM_TIMEOUT=4, imem_stall held 6 cycles -> imem_err rises on the 4th stall cycle and stays 1 after imem_done; cleared only when rst=0.
- if_inst[15:11]=00000 -> halt=1 and pc_en=0 forever. Repeat with br_ctl=1 in the same cycle -> no halt, redirect applied.
